pacoblaze_alu_arbiter: RTL
==========================

PACOBLAZE_ALU_ARBITER -- requirements
Module: pacoblaze_alu_arbiter

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; the polarity and synchronicity are fixed.
REQ-002 Parameter OPW, default `operation_width`, SHALL set the width of the ALU operation code.
REQ-003 Parameter DW, default `operand_width` (8), SHALL set the operand and result width, and SHALL NOT be overridden.
REQ-004 The module SHALL have the following ports:
- clk  input  1  clock.
- reset_n  input  1  async active-low reset.
- rN_valid (N=0,1)  input  1  requester N has an op pending.
- rN_ready  output  1  op of requester N accepted this cycle.
- rN_lock  input  1  keep the grant on N after this op (multi-byte chains).
- rN_fe  input  1  op updates N's flag context.
- rN_operation  input  OPW  ALU main operation.
- rN_shift_operation  input  3  rotate/shift select.
- rN_shift_direction  input  1  0 = left, 1 = right.
- rN_shift_constant  input  1  shift fill constant.
- rN_a, rN_b  input  DW  operands.
- rsp_valid  output  1  result register full.
- rsp_ready  input  1  consumer takes result.
- rsp_id  output  1  requester that owns the result.
- rsp_result  output  DW  registered ALU result.
- rsp_carry, rsp_zero  output  1  registered ALU flags.
- carryN, zeroN  output  1  flag context of requester N.

Function
REQ-005 The module SHALL instantiate one pacoblaze_alu and drive it combinationally from the granted requester's fields.
REQ-006 The ALU carry_in SHALL be carryN of the granted requester N.
REQ-007 Capacity: "space" SHALL be defined as (!rsp_valid | rsp_ready).
REQ-008 A grant with no valid requester SHALL assert no ready.
REQ-009 rN_ready SHALL equal (grant==N) & rN_valid & space.
REQ-010 rN_ready SHALL be combinational; a handshake SHALL be rN_valid & rN_ready.
REQ-011 On a handshake, the result register SHALL load result, carry_out, zero_out and id at the next edge; rsp_valid SHALL be 1 from that edge, giving latency 1 cycle.
REQ-012 A same-cycle drain (rsp_ready) and accept SHALL give back-to-back results with no bubble.
REQ-013 While rsp_valid=1 and rsp_ready=0, the rsp_* outputs SHALL be held stable.
REQ-014 While rsp_valid=1 and rsp_ready=0, no ready SHALL assert and no flags SHALL change.
REQ-015 rsp_valid SHALL clear on drain when no new handshake occurs in the same cycle.
REQ-016 Flags: on a handshake with rN_fe=1, carryN<=carry_out and zeroN<=zero_out.
REQ-017 With rN_fe=0, carryN and zeroN SHALL be unchanged.
REQ-018 The other requester's flag context SHALL never change on N's handshake.
REQ-019 The arbitration FSM SHALL have states OPEN, LOCK0 and LOCK1.
REQ-020 In OPEN with only one requester valid, that requester SHALL be granted.
REQ-021 In OPEN with both requesters valid, the requester other than last_grant SHALL be granted (round-robin).
REQ-022 last_grant SHALL update on every handshake.
REQ-023 In LOCKN, the grant SHALL be N unconditionally; the other requester SHALL be starved even if rN_valid=0.
REQ-024 On a handshake by N with rN_lock=1, the FSM SHALL go to LOCKN.
REQ-025 On a handshake by N with rN_lock=0, the FSM SHALL go to OPEN.
REQ-026 Without a handshake, the FSM state SHALL hold.
REQ-027 The FSM SHALL NOT take a lock when the requester is not ready, e.g. under backpressure.

Reset
REQ-028 On reset_n=0, the module SHALL asynchronously set state=OPEN, last_grant=1 (so r0 wins the first tie), rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_zero=0, and all carryN/zeroN=0.
REQ-029 Reset SHALL abandon any held result and any lock in progress.
REQ-030 rN_ready SHALL be 0 while reset_n=0.

Verification
REQ-031 Reset scenario: assert reset_n=0 during LOCK1 with rsp_valid=1 -> rsp_valid=0, all flags 0; after release, a tie of r0/r1 grants r0 first.
REQ-032 Single-op scenario: r0 op_add a=F0 b=20 fe=1 -> next cycle rsp_valid=1, result=10, carry=1, zero=0, id=0; carry0=1, carry1=0.
REQ-033 Round-robin scenario: r0 and r1 continuously valid, lock=0, rsp_ready=1 -> rsp_id sequence 0,1,0,1 with one result per cycle.
REQ-034 Lock-chain scenario: r1 op_add FF+01 lock=1, then r1 op_addcy 00+00 lock=0, with r0 valid throughout -> r1 results 00 (carry 1), then 01 (carry 0); r0 granted only after the chain.
REQ-035 Backpressure scenario: rsp_ready=0 for 3 cycles with r0 valid -> rsp_* stable, r0_ready=0, flags unchanged; when rsp_ready=1 -> r0 accepted in the same cycle and its result appears next cycle.
REQ-036 Flag-enable scenario: r0 op_load b=00 fe=0 following a carry-setting op -> carry0 remains 1 and zero0 unchanged, while rsp_zero=1.

Source files
------------

// File: rtl/pacoblaze_alu_arbiter_if.sv
// Request/response bundle between two ALU requesters and the shared-ALU arbiter.
// The master side drives requests and drains results; the slave side is the arbiter.
interface pacoblaze_alu_arbiter_if #(
    parameter int OPW = 4,
    parameter int DW  = 8
);
    logic           r0_valid;
    logic           r0_ready;
    logic           r0_lock;
    logic           r0_fe;
    logic [OPW-1:0] r0_operation;
    logic [2:0]     r0_shift_operation;
    logic           r0_shift_direction;
    logic           r0_shift_constant;
    logic [DW-1:0]  r0_a;
    logic [DW-1:0]  r0_b;

    logic           r1_valid;
    logic           r1_ready;
    logic           r1_lock;
    logic           r1_fe;
    logic [OPW-1:0] r1_operation;
    logic [2:0]     r1_shift_operation;
    logic           r1_shift_direction;
    logic           r1_shift_constant;
    logic [DW-1:0]  r1_a;
    logic [DW-1:0]  r1_b;

    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [DW-1:0]  rsp_result;
    logic           rsp_carry;
    logic           rsp_zero;

    logic           carry0;
    logic           zero0;
    logic           carry1;
    logic           zero1;

    modport master (
        output r0_valid, r0_lock, r0_fe, r0_operation, r0_shift_operation,
               r0_shift_direction, r0_shift_constant, r0_a, r0_b,
        output r1_valid, r1_lock, r1_fe, r1_operation, r1_shift_operation,
               r1_shift_direction, r1_shift_constant, r1_a, r1_b,
        output rsp_ready,
        input  r0_ready, r1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero,
        input  carry0, zero0, carry1, zero1
    );

    modport slave (
        input  r0_valid, r0_lock, r0_fe, r0_operation, r0_shift_operation,
               r0_shift_direction, r0_shift_constant, r0_a, r0_b,
        input  r1_valid, r1_lock, r1_fe, r1_operation, r1_shift_operation,
               r1_shift_direction, r1_shift_constant, r1_a, r1_b,
        input  rsp_ready,
        output r0_ready, r1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero,
        output carry0, zero0, carry1, zero1
    );
endinterface

// File: rtl/pacoblaze_alu_arbiter.sv
// Two requesters share one PacoBlaze-style ALU: round-robin grant with lockable
// multi-byte chains, a one-deep result register and a flag context per requester.

module pacoblaze_alu #(
    parameter int OPW = 4,
    parameter int DW  = 8
) (
    input  logic [OPW-1:0] operation,
    input  logic [2:0]     shift_operation,
    input  logic           shift_direction,
    input  logic           shift_constant,
    input  logic [DW-1:0]  operand_a,
    input  logic [DW-1:0]  operand_b,
    input  logic           carry_in,
    output logic [DW-1:0]  result,
    output logic           carry_out,
    output logic           zero_out
);
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(0);
    localparam logic [OPW-1:0] OP_AND   = OPW'(1);
    localparam logic [OPW-1:0] OP_OR    = OPW'(2);
    localparam logic [OPW-1:0] OP_XOR   = OPW'(3);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(4);
    localparam logic [OPW-1:0] OP_ADDCY = OPW'(5);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(6);
    localparam logic [OPW-1:0] OP_SUBCY = OPW'(7);
    localparam logic [OPW-1:0] OP_SHIFT = OPW'(8);

    logic [DW:0] sum;
    logic        fill;

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sum       = '0;
        fill      = shift_constant;
        result    = operand_b;
        carry_out = 1'b0;
        case (operation)
            OP_LOAD:  result = operand_b;
            OP_AND:   result = operand_a & operand_b;
            OP_OR:    result = operand_a | operand_b;
            OP_XOR:   result = operand_a ^ operand_b;
            OP_ADD: begin
                sum = {1'b0, operand_a} + {1'b0, operand_b};
                {carry_out, result} = sum;
            end
            OP_ADDCY: begin
                sum = {1'b0, operand_a} + {1'b0, operand_b} + {{DW{1'b0}}, carry_in};
                {carry_out, result} = sum;
            end
            OP_SUB: begin
                sum = {1'b0, operand_a} - {1'b0, operand_b};
                {carry_out, result} = sum;
            end
            OP_SUBCY: begin
                sum = {1'b0, operand_a} - {1'b0, operand_b} - {{DW{1'b0}}, carry_in};
                {carry_out, result} = sum;
            end
            OP_SHIFT: begin
                // shift_operation: 1 = fill from carry, 2 = rotate, 3 = replicate edge bit
                case (shift_operation)
                    3'd1:    fill = carry_in;
                    3'd2:    fill = shift_direction ? operand_a[0] : operand_a[DW-1];
                    3'd3:    fill = shift_direction ? operand_a[DW-1] : operand_a[0];
                    default: fill = shift_constant;
                endcase
                if (shift_direction) begin
                    result    = {fill, operand_a[DW-1:1]};
                    carry_out = operand_a[0];
                end else begin
                    result    = {operand_a[DW-2:0], fill};
                    carry_out = operand_a[DW-1];
                end
            end
            default:  result = operand_b;
        endcase
        zero_out = (result == '0);
    end
endmodule

module pacoblaze_alu_arbiter #(
    parameter int OPW = 4,
    parameter int DW  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pacoblaze_alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        OPEN  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    arb_state_e    state_q;
    logic          last_q;
    logic          rsp_valid_q;
    logic          rsp_id_q;
    logic [DW-1:0] rsp_result_q;
    logic          rsp_carry_q;
    logic          rsp_zero_q;
    logic [1:0]    carry_q;
    logic [1:0]    zero_q;

    logic           grant;
    logic           space;
    logic           handshake;
    logic [OPW-1:0] sel_operation;
    logic [2:0]     sel_shift_operation;
    logic           sel_shift_direction;
    logic           sel_shift_constant;
    logic [DW-1:0]  sel_a;
    logic [DW-1:0]  sel_b;
    logic           sel_lock;
    logic           sel_fe;
    logic [DW-1:0]  alu_result;
    logic           alu_carry;
    logic           alu_zero;

    always_comb begin
        grant = 1'b0;
        case (state_q)
            LOCK0:   grant = 1'b0;
            LOCK1:   grant = 1'b1;
            default: grant = (bus.r0_valid & bus.r1_valid) ? ~last_q : bus.r1_valid;
        endcase
    end

    // Ready is gated by reset_n so nothing is accepted while reset is held.
    assign space        = ~rsp_valid_q | bus.rsp_ready;
    assign bus.r0_ready = reset_n & ~grant & bus.r0_valid & space;
    assign bus.r1_ready = reset_n &  grant & bus.r1_valid & space;
    assign handshake    = bus.r0_ready | bus.r1_ready;

    always_comb begin
        if (grant) begin
            sel_operation       = bus.r1_operation;
            sel_shift_operation = bus.r1_shift_operation;
            sel_shift_direction = bus.r1_shift_direction;
            sel_shift_constant  = bus.r1_shift_constant;
            sel_a               = bus.r1_a;
            sel_b               = bus.r1_b;
            sel_lock            = bus.r1_lock;
            sel_fe              = bus.r1_fe;
        end else begin
            sel_operation       = bus.r0_operation;
            sel_shift_operation = bus.r0_shift_operation;
            sel_shift_direction = bus.r0_shift_direction;
            sel_shift_constant  = bus.r0_shift_constant;
            sel_a               = bus.r0_a;
            sel_b               = bus.r0_b;
            sel_lock            = bus.r0_lock;
            sel_fe              = bus.r0_fe;
        end
    end

    pacoblaze_alu #(.OPW(OPW), .DW(DW)) u_alu (
        .operation       (sel_operation),
        .shift_operation (sel_shift_operation),
        .shift_direction (sel_shift_direction),
        .shift_constant  (sel_shift_constant),
        .operand_a       (sel_a),
        .operand_b       (sel_b),
        .carry_in        (carry_q[grant]),
        .result          (alu_result),
        .carry_out       (alu_carry),
        .zero_out        (alu_zero)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= OPEN;
            last_q       <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            carry_q      <= '0;
            zero_q       <= '0;
        end else if (handshake) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= grant;
            rsp_result_q <= alu_result;
            rsp_carry_q  <= alu_carry;
            rsp_zero_q   <= alu_zero;
            last_q       <= grant;
            state_q      <= !sel_lock ? OPEN : (grant ? LOCK1 : LOCK0);
            if (sel_fe) begin
                carry_q[grant] <= alu_carry;
                zero_q[grant]  <= alu_zero;
            end
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.carry0     = carry_q[0];
    assign bus.zero0      = zero_q[0];
    assign bus.carry1     = carry_q[1];
    assign bus.zero1      = zero_q[1];
endmodule
